clk_ratio_gen: RTL
==================

Name: clk_ratio_gen

Overview:
- Parametrised successor to the fixed 8:1 memory-clock/CPU-clock relationship used in the microcontroller benches.
- Runs on the fast memory clock and produces a divided CPU clock with a runtime-programmable ratio.
- Also produces single-cycle clock-enable strobes and a sequenced, synchronously released CPU reset.
- Adds halt, optional single-step, and a CPU cycle counter; sits between the clock source and the Microcontroller top level.

Parameters:
- DIV_W, 4: width of the half-period divisor.
- DIV_DEFAULT, 8: half-period in i_CLK cycles loaded at reset. Range 1..2^DIV_W-1.
- RST_HOLD, 4: number of complete output periods o_RST_CPU stays low after reset.
- CNT_W, 16: width of o_CYC_CNT.

Ports:
- i_CLK  in  1  memory-rate clock.
- i_RST  in  1  asynchronous, active-low reset.
- i_DIV  in  DIV_W  new half-period value.
- i_DIV_LOAD  in  1  one-cycle strobe that captures i_DIV.
- i_HALT  in  1  level; requests the divided clock to stop.
- i_STEP  in  1  single-step request; rising edge detected internally.
- o_CLK_DIV  out  1  divided CPU clock, 50% duty.
- o_CE_RISE  out  1  high during the last i_CLK cycle before o_CLK_DIV rises.
- o_CE_FALL  out  1  high during the last i_CLK cycle before o_CLK_DIV falls.
- o_RST_CPU  out  1  active-low CPU reset.
- o_RUNNING  out  1  high in S_RUN or S_STEP.
- o_CYC_CNT  out  CNT_W  count of o_CLK_DIV rising edges since o_RST_CPU released.

Behaviour:
- Reset (i_RST=0, asynchronous):
  - cnt=0, half=DIV_DEFAULT, state=S_RESET.
  - All outputs 0; o_RST_CPU=0.
- Counter:
  - cnt counts 0..half-1 while state is not S_HALT.
  - At cnt==half-1: cnt wraps to 0 and o_CLK_DIV toggles. That cycle is the "wrap".
  - A wrap with o_CLK_DIV=1 is a "period boundary".
  - half=1 gives a period of 2 i_CLK cycles.
- Strobes:
  - o_CE_RISE = wrap & ~o_CLK_DIV. o_CE_FALL = wrap & o_CLK_DIV.
  - Both are decoded from registered state only; there is no input-to-output combinational path.
  - Both are forced to 0 in S_HALT.
- Divisor load:
  - i_DIV_LOAD captures i_DIV into a shadow register and sets a pending flag.
  - A pending value is applied at the next period boundary, so the duty cycle stays glitch-free.
  - A load coinciding with a period boundary applies at that boundary.
  - i_DIV==0 is treated as 1.
  - A second load before application overwrites the shadow register (last load wins).
- FSM:
  - S_RESET: the divider runs. After RST_HOLD period boundaries, go to S_RUN and set o_RST_CPU=1; the release is aligned to a period boundary.
  - S_RUN: o_CYC_CNT increments on each o_CE_RISE and wraps modulo 2^CNT_W. If i_HALT=1 at a period boundary, go to S_HALT.
  - S_HALT: cnt held at 0, o_CLK_DIV held at 0, o_CYC_CNT frozen. If i_HALT=0, go to S_RUN next cycle; the first o_CE_RISE follows half cycles later.
  - S_STEP: see Optional Feature.
- i_HALT asserted during S_RESET is ignored until S_RUN is reached; it then takes effect at the next period boundary.
- Reset mid-operation: immediate return to reset values from any state; a pending divisor load is discarded.

Optional Feature:
- Macro: CLK_RATIO_GEN_STEP_EN.
- With the macro defined:
  - A rising edge on i_STEP in S_HALT enters S_STEP.
  - S_STEP runs exactly one full period (one o_CE_RISE, one o_CE_FALL, o_CYC_CNT+1) and then returns to S_HALT at the period boundary.
  - i_STEP edges outside S_HALT are ignored.
  - If i_HALT=0 during S_STEP, go to S_RUN at the period boundary.
- Without the macro: the i_STEP port remains but is ignored, and S_STEP is unreachable.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - the state encoding S_RESET/S_RUN/S_HALT/S_STEP (2 bits);
  - the default constants DIV_DEFAULT and RST_HOLD.
- One natural sub-module, clk_ratio_div: the cnt/half/toggle core with shadow-register load. It outputs the wrap and period-boundary signals, and takes a hold input driven by the FSM.

Test Plan:
- Reset, DIV_DEFAULT=8, RST_HOLD=4:
  - o_CLK_DIV period is 16 cycles.
  - o_RST_CPU rises at cycle 64, coincident with a falling edge of o_CLK_DIV.
  - o_CYC_CNT reads 5 after a further 80 cycles.
- Load i_DIV=3 mid-period:
  - Current period completes at 16 cycles; subsequent periods are 6 cycles.
  - Load i_DIV=0: period becomes 2.
- Assert i_HALT mid-period:
  - Stop happens at the next period boundary; o_CLK_DIV stays 0, no strobes, o_CYC_CNT frozen.
  - Deassert: first o_CE_RISE 1+half cycles later.
- With CLK_RATIO_GEN_STEP_EN: three i_STEP pulses while halted give exactly 3 o_CE_RISE and o_CYC_CNT+3.
  - Without the macro: 0 pulses.
- Pull i_RST low during S_RUN with a pending load: all outputs 0 immediately. After release, the period is again DIV_DEFAULT-based (16).
- CNT_W=4: run 17 CPU cycles; o_CYC_CNT wraps to 1.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock ratio generator: FSM state encoding and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_clk_pkg;

    localparam int DIV_DEFAULT = 8;
    localparam int RST_HOLD    = 4;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

endpackage

// File: rtl/clk_ratio_div.sv
// Half-period counter and toggle core with a shadowed divisor that only changes on a period boundary.
// Latency: wrap/boundary decode is combinational from registered state; a new divisor takes effect at the next boundary.
// Backpressure: none; i_HOLD parks the counter at zero with the clock low.
module clk_ratio_div #(
    parameter int DIV_W       = 4,
    parameter int DIV_DEFAULT = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [DIV_W-1:0] i_DIV,
    input  logic             i_DIV_LOAD,
    input  logic             i_HOLD,
    output logic             o_CLK_DIV,
    output logic             o_WRAP,
    output logic             o_BOUNDARY
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_half;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_clk;

    logic [DIV_W-1:0] w_div;
    logic             w_wrap;
    logic             w_bound;

    // A zero divisor would never wrap; clamp it to the fastest legal ratio.
    assign w_div   = (i_DIV == '0) ? ONE : i_DIV;
    assign w_wrap  = ~i_HOLD & (r_cnt == (r_half - ONE));
    assign w_bound = w_wrap & r_clk;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_cnt    <= '0;
            r_half   <= HALF_RST;
            r_shadow <= HALF_RST;
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
        end else begin
            if (i_DIV_LOAD) begin
                r_shadow <= w_div;
                r_pend   <= 1'b1;
            end

            if (i_HOLD) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (w_wrap) begin
                r_cnt <= '0;
                r_clk <= ~r_clk;
            end else begin
                r_cnt <= r_cnt + ONE;
            end

            // A load landing on the boundary itself bypasses the shadow so it is not delayed a full period.
            if (w_bound) begin
                if (i_DIV_LOAD) begin
                    r_half <= w_div;
                    r_pend <= 1'b0;
                end else if (r_pend) begin
                    r_half <= r_shadow;
                    r_pend <= 1'b0;
                end
            end
        end
    end

    assign o_CLK_DIV  = r_clk;
    assign o_WRAP     = w_wrap;
    assign o_BOUNDARY = w_bound;

endmodule

// File: rtl/clk_ratio_gen.sv
// Divided CPU clock with strobes, sequenced reset release, halt and cycle counter; single-step under CLK_RATIO_GEN_STEP_EN.
// Latency: strobes decode registered state in the cycle before each divided-clock edge; FSM reacts at period boundaries.
// Backpressure: none; i_HALT stops the divided clock at the next period boundary.
module clk_ratio_gen #(
    parameter int DIV_W       = 4,
    parameter int DIV_DEFAULT = cpu_clk_pkg::DIV_DEFAULT,
    parameter int RST_HOLD    = cpu_clk_pkg::RST_HOLD,
    parameter int CNT_W       = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [DIV_W-1:0] i_DIV,
    input  logic             i_DIV_LOAD,
    input  logic             i_HALT,
    input  logic             i_STEP,
    output logic             o_CLK_DIV,
    output logic             o_CE_RISE,
    output logic             o_CE_FALL,
    output logic             o_RST_CPU,
    output logic             o_RUNNING,
    output logic [CNT_W-1:0] o_CYC_CNT
);

    import cpu_clk_pkg::*;

    localparam int RH_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t            r_state;
    logic              r_rst_cpu;
    logic              r_running;
    logic [CNT_W-1:0]  r_cyc;
    logic [RH_W-1:0]   r_rst_cnt;

    logic              w_clk_div;
    logic              w_wrap;
    logic              w_bound;
    logic              w_rise;
    logic              w_hold;
    logic              w_step_rise;

    assign w_hold = (r_state == S_HALT);

    clk_ratio_div #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_DIV      (i_DIV),
        .i_DIV_LOAD (i_DIV_LOAD),
        .i_HOLD     (w_hold),
        .o_CLK_DIV  (w_clk_div),
        .o_WRAP     (w_wrap),
        .o_BOUNDARY (w_bound)
    );

    assign w_rise = w_wrap & ~w_clk_div;

`ifdef CLK_RATIO_GEN_STEP_EN
    logic r_step_d;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= i_STEP;
        end
    end

    assign w_step_rise = i_STEP & ~r_step_d;
`else
    logic w_step_unused;

    assign w_step_unused = i_STEP;
    assign w_step_rise   = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state   <= S_RESET;
            r_rst_cpu <= 1'b0;
            r_running <= 1'b0;
            r_cyc     <= '0;
            r_rst_cnt <= '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    // Releasing on a boundary means the CPU sees a clean low phase first.
                    if (w_bound) begin
                        if (r_rst_cnt == RH_W'(RST_HOLD - 1)) begin
                            r_state   <= S_RUN;
                            r_rst_cpu <= 1'b1;
                            r_running <= 1'b1;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + RH_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (w_rise) begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                    if (w_bound && i_HALT) begin
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (!i_HALT) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else if (w_step_rise) begin
                        r_state   <= S_STEP;
                        r_running <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (w_rise) begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                    if (w_bound) begin
                        if (i_HALT) begin
                            r_state   <= S_HALT;
                            r_running <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

    assign o_CLK_DIV = w_clk_div;
    assign o_CE_RISE = w_rise;
    assign o_CE_FALL = w_bound;
    assign o_RST_CPU = r_rst_cpu;
    assign o_RUNNING = r_running;
    assign o_CYC_CNT = r_cyc;

endmodule
